// File: rtl/mmio_io_bridge.sv
// Memory-mapped bridge exposing debounced buttons, sticky press flags, LEDs and a
// programmable frame-tick timer to the processor data-memory port.
module mmio_io_bridge #(
    parameter int          NUM_BTN         = 4,
    parameter int          NUM_LED         = 16,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [11:0] BASE_ADDR       = 12'hF00
) (
    input  logic               clock,
    input  logic               CPU_RESETN,
    input  logic [11:0]        addr,
    input  logic               wren,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               hit,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_LED-1:0] led,
    output logic               tick
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [11:0] OFF_BTN_STATE   = 12'd0;
    localparam logic [11:0] OFF_BTN_PRESS   = 12'd1;
    localparam logic [11:0] OFF_LED         = 12'd2;
    localparam logic [11:0] OFF_TICK_PERIOD = 12'd3;
    localparam logic [11:0] OFF_TICK_COUNT  = 12'd4;
    localparam logic [11:0] OFF_STATUS      = 12'd5;

    logic [11:0]        off;
    logic               in_win;
    logic               wr_press, wr_led, wr_period, wr_count, wr_status;

    logic [NUM_BTN-1:0] sync1, sync2, stable, press, accept, rise;
    logic [CNT_W-1:0]   db_cnt [NUM_BTN];

    logic [31:0]        period, tmr_cnt, count;
    logic               pending, fire;
    logic [31:0]        rd_mux;

    // Wrapping subtraction keeps the window test to a single compare.
    assign off    = addr - BASE_ADDR;
    assign in_win = (off < 12'd6);

    assign wr_press  = wren && in_win && (off == OFF_BTN_PRESS);
    assign wr_led    = wren && in_win && (off == OFF_LED);
    assign wr_period = wren && in_win && (off == OFF_TICK_PERIOD);
    assign wr_count  = wren && in_win && (off == OFF_TICK_COUNT);
    assign wr_status = wren && in_win && (off == OFF_STATUS);

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_BTN; i++)
            accept[i] = (sync2[i] != stable[i]) && (db_cnt[i] == CNT_LAST);
    end

    // A differing synced value that is accepted can only be a rising edge if it is 1.
    assign rise = accept & sync2;

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            stable <= '0;
            for (int i = 0; i < NUM_BTN; i++)
                db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            press <= '0;
            led   <= '0;
        end else begin
            press <= (press & ~(wr_press ? wdata[NUM_BTN-1:0] : '0)) | rise;
            if (wr_led)
                led <= wdata[NUM_LED-1:0];
        end
    end

    // A period write restarts the phase, so it suppresses any tick due on that edge.
    assign fire = (period != 32'd0) && (tmr_cnt == period - 32'd1) && !wr_period;

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            period  <= '0;
            tmr_cnt <= '0;
            count   <= '0;
            pending <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= fire;
            if (wr_period) begin
                period  <= wdata;
                tmr_cnt <= '0;
            end else if (fire) begin
                tmr_cnt <= '0;
            end else if (period != 32'd0) begin
                tmr_cnt <= tmr_cnt + 32'd1;
            end
            if (wr_count)
                count <= '0;
            else if (fire)
                count <= count + 32'd1;
            if (fire)
                pending <= 1'b1;
            else if (wr_status && wdata[0])
                pending <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_BTN_STATE:   rd_mux[NUM_BTN-1:0] = stable;
            OFF_BTN_PRESS:   rd_mux[NUM_BTN-1:0] = press;
            OFF_LED:         rd_mux[NUM_LED-1:0] = led;
            OFF_TICK_PERIOD: rd_mux = period;
            OFF_TICK_COUNT:  rd_mux = count;
            OFF_STATUS:      rd_mux[0] = pending;
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rdata <= '0;
            hit   <= 1'b0;
        end else begin
            rdata <= in_win ? rd_mux : 32'd0;
            hit   <= in_win;
        end
    end

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Scoreboard bench for mmio_io_bridge: the driver pushes the reference model's expected
// outputs per edge, an independent monitor pops and compares after each edge.
module tb_mmio_io_bridge;

    localparam int          NB   = 4;
    localparam int          NL   = 16;
    localparam int          D    = 4;
    localparam logic [11:0] BASE = 12'hF00;

    logic          clock = 1'b0;
    logic          CPU_RESETN;
    logic [11:0]   addr;
    logic          wren;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          hit;
    logic [NB-1:0] btn_raw;
    logic [NL-1:0] led;
    logic          tick;

    mmio_io_bridge #(
        .NUM_BTN(NB), .NUM_LED(NL), .DEBOUNCE_CYCLES(D), .BASE_ADDR(BASE)
    ) dut (
        .clock(clock), .CPU_RESETN(CPU_RESETN), .addr(addr), .wren(wren), .wdata(wdata),
        .rdata(rdata), .hit(hit), .btn_raw(btn_raw), .led(led), .tick(tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          hit;
        logic [31:0]   rdata;
        logic          tick;
        logic [NL-1:0] led;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [NB-1:0] m_stable, m_press, cur_btn;
    logic [NL-1:0] m_led;
    logic [31:0]   m_period, m_count;
    logic          m_pending;
    longint        m_since;
    logic [NB-1:0] m_hist[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_stable  = '0;
        m_press   = '0;
        m_led     = '0;
        m_period  = '0;
        m_count   = '0;
        m_pending = 1'b0;
        m_since   = 0;
        m_hist.delete();
        repeat (D + 1) m_hist.push_back('0);
    endtask

    // One clock edge of the register map, from the rules: reads see pre-edge state,
    // a level is accepted once D consecutive synchronised samples all agree.
    task automatic model_step(input logic rstn, input logic [11:0] a, input logic we,
                              input logic [31:0] d, input logic [NB-1:0] b, output exp_t e);
        int            off;
        logic          inwin, fire, same;
        logic [31:0]   rv;
        logic [NB-1:0] new_stable, rise;
        if (!rstn) begin
            model_reset();
            e.hit = 1'b0; e.rdata = '0; e.tick = 1'b0; e.led = '0;
            return;
        end
        off   = int'(a) - int'(BASE);
        inwin = (off >= 0) && (off <= 5);
        case (off)
            0:       rv = {28'b0, m_stable};
            1:       rv = {28'b0, m_press};
            2:       rv = {16'b0, m_led};
            3:       rv = m_period;
            4:       rv = m_count;
            5:       rv = {31'b0, m_pending};
            default: rv = '0;
        endcase
        m_hist.push_front(b);
        new_stable = m_stable;
        for (int ch = 0; ch < NB; ch++) begin
            same = 1'b1;
            for (int j = 2; j <= D + 1; j++)
                if (m_hist[j][ch] != m_hist[2][ch]) same = 1'b0;
            if (same) new_stable[ch] = m_hist[2][ch];
        end
        void'(m_hist.pop_back());
        rise = new_stable & ~m_stable;
        m_stable = new_stable;
        if (we && off == 1) m_press = m_press & ~d[NB-1:0];
        m_press = m_press | rise;
        if (we && off == 2) m_led = d[NL-1:0];
        fire = 1'b0;
        if (we && off == 3) begin
            m_period = d;
            m_since  = 0;
        end else if (m_period != 0) begin
            m_since++;
            fire = ((m_since % longint'(m_period)) == 0);
        end
        if (fire) begin
            m_count   = m_count + 1;
            m_pending = 1'b1;
        end
        if (we && off == 4) m_count = '0;
        if (we && off == 5 && d[0] && !fire) m_pending = 1'b0;
        e.hit   = inwin;
        e.rdata = inwin ? rv : 32'd0;
        e.tick  = fire;
        e.led   = m_led;
    endtask

    task automatic cycle(input logic rstn, input logic [11:0] a, input logic we,
                         input logic [31:0] d, input logic [NB-1:0] b);
        exp_t e;
        @(negedge clock);
        CPU_RESETN = rstn; addr = a; wren = we; wdata = d; btn_raw = b;
        model_step(rstn, a, we, d, b, e);
        q.push_back(e);
    endtask

    task automatic rd(input logic [11:0] a);
        cycle(1'b1, a, 1'b0, $urandom, cur_btn);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cycle(1'b1, a, 1'b1, d, cur_btn);
    endtask

    task automatic idle();
        cycle(1'b1, 12'h000, 1'b0, 32'd0, cur_btn);
    endtask

    // Returns when the next issued cycle lands on a tick edge.
    task automatic wait_tick_edge();
        for (int i = 0; i < 64; i++) begin
            if (m_period != 0 && ((m_since + 1) % longint'(m_period)) == 0) return;
            idle();
        end
        checks++;
        errors++;
        $display("FAIL wait_tick_edge: no tick edge within 64 cycles, period %0d", m_period);
    endtask

    task automatic random_cycle();
        logic [11:0] a;
        logic [31:0] d;
        logic        we;
        int          r, idx;
        if ($urandom_range(0, 7) == 0) begin
            idx = $urandom_range(0, NB - 1);
            cur_btn[idx] = ~cur_btn[idx];
        end
        r = $urandom_range(0, 9);
        if (r <= 5)      a = BASE + 12'(r);
        else if (r == 6) a = 12'hEFF;
        else if (r == 7) a = BASE + 12'd6;
        else             a = 12'($urandom);
        we = ($urandom_range(0, 2) == 0);
        d  = $urandom;
        if (a == BASE + 12'd3) d = $urandom_range(0, 7);
        cycle(1'b1, a, we, d, cur_btn);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("hit", {31'b0, hit}, {31'b0, e.hit});
                if (e.hit) check("rdata", rdata, e.rdata);
                check("tick", {31'b0, tick}, {31'b0, e.tick});
                check("led", {16'b0, led}, {16'b0, e.led});
            end
        end
    end

    initial begin : driver
        CPU_RESETN = 1'b0; addr = '0; wren = 1'b0; wdata = '0; btn_raw = '0; cur_btn = '0;
        model_reset();
        repeat (3) cycle(1'b0, 12'h000, 1'b0, 32'd0, '0);
        for (int i = 0; i < 6; i++) rd(BASE + 12'(i));
        rd(12'hEFF);

        wr(BASE + 12'd2, 32'hFFFF_A5A5);
        rd(BASE + 12'd2);

        cur_btn = 4'b0010;
        repeat (3) rd(BASE);
        cur_btn = 4'b0000;
        repeat (8) begin rd(BASE); rd(BASE + 12'd1); end

        cur_btn = 4'b0010;
        repeat (8) rd(BASE);
        rd(BASE + 12'd1);
        wr(BASE + 12'd1, 32'h2);
        rd(BASE + 12'd1);

        wr(BASE + 12'd3, 32'd5);
        wait_tick_edge();
        wr(BASE + 12'd5, 32'd1);
        wait_tick_edge(); idle();
        wait_tick_edge(); idle();
        rd(BASE + 12'd4);
        rd(BASE + 12'd5);
        wr(BASE + 12'd5, 32'd1);
        rd(BASE + 12'd5);
        wait_tick_edge();
        wr(BASE + 12'd4, 32'hDEAD_BEEF);
        rd(BASE + 12'd4);

        cur_btn = 4'b0110;
        repeat (5) rd(BASE);
        wr(BASE + 12'd1, 32'h4);
        rd(BASE + 12'd1);

        repeat (1500) random_cycle();

        cur_btn = '0;
        wr(BASE + 12'd3, 32'd0);
        repeat (10) idle();
        wr(BASE + 12'd2, 32'h0000_1234);
        wr(BASE + 12'd3, 32'd5);
        cur_btn = 4'b1000;
        wait_tick_edge();
        idle();
        cycle(1'b0, 12'h000, 1'b0, 32'd0, cur_btn);
        #1;
        check("reset_led", {16'b0, led}, 32'd0);
        check("reset_tick", {31'b0, tick}, 32'd0);
        cycle(1'b0, 12'h000, 1'b0, 32'd0, cur_btn);
        rd(BASE + 12'd3);
        repeat (20) rd(BASE);
        rd(BASE + 12'd1);

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clock);
            #2;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_io_bridge.md
# mmio_io_bridge

Parametrised memory-mapped I/O bridge between the processor data-memory port and the board's buttons, LEDs and a frame-tick timer. It generalises the hard-wired button/LED/clock-divider handling of the top-level wrapper into one block. The block adds N-channel debouncing, sticky press flags, a programmable periodic tick for simulation frame pacing, and a software-readable tick counter. It sits beside the RAM. The wrapper routes `rdata` to the processor when `hit` is high, and routes RAM data otherwise.

## Interface
- `NUM_BTN`, 4: button channels, 1..32
- `NUM_LED`, 16: LED outputs, 1..32
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a level change, ≥2
- `BASE_ADDR`, 12'hF00: word address of register 0; window is BASE_ADDR..BASE_ADDR+5
- `clock`  in  1  single clock, rising edge
- `CPU_RESETN`  in  1  asynchronous, active-low reset
- `addr`  in  12  dmem word address
- `wren`  in  1  write strobe
- `wdata`  in  32  write data
- `rdata`  out  32  registered read data
- `hit`  out  1  registered: previous-cycle `addr` was inside the window
- `btn_raw`  in  NUM_BTN  asynchronous button pins
- `led`  out  NUM_LED  LED register contents
- `tick`  out  1  one-cycle pulse at each timer period

## Operation
- Register map, offsets from BASE_ADDR. Unused high bits read 0.
  - 0 BTN_STATE, RO: debounced levels.
  - 1 BTN_PRESS, R/W1C: sticky rising-edge flags.
  - 2 LED, R/W: low NUM_LED bits.
  - 3 TICK_PERIOD, R/W: 32 bit; 0 disables the timer.
  - 4 TICK_COUNT, RO: ticks elapsed, wraps at 2^32. Any write clears it to 0.
  - 5 STATUS: bit0 tick_pending, sticky, W1C.
- Writes with `wren`=0 or `addr` outside the window have no effect. Writes to BTN_STATE are ignored.
- Debounce, per channel:
  - 2-flop synchroniser feeds the filter.
  - Counter clears while the synced value equals the stable value. It increments while they differ.
  - When the counter reaches DEBOUNCE_CYCLES−1 and they still differ, the stable value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches the stable value.
- Press flag: set on a stable 0→1 transition. Cleared by writing 1 to its bit. If a set and a clear hit the same bit in the same cycle, the set wins.
- Timer:
  - Counter runs while PERIOD≠0.
  - When counter = PERIOD−1: `tick`=1 for one cycle, counter returns to 0, TICK_COUNT increments, tick_pending is set.
  - A write to TICK_PERIOD clears the counter. Counting restarts from 0 with the new period on the next cycle.
  - If a tick and a W1C of tick_pending occur in the same cycle, pending stays 1.
  - If a tick and a TICK_COUNT write occur in the same cycle, the result is 0 (the write wins).
  - PERIOD=1: `tick` is high every cycle.

## Timing
- Reset (async assert, sync release), all outputs and state to 0: `rdata`=0, `hit`=0, `led`=0, `tick`=0; stable levels, flags, counters, PERIOD, COUNT, pending all 0.
- Read latency 1 cycle: `addr` sampled at edge k; `rdata`/`hit` valid after edge k, reflecting register state before edge k's updates.
- Read-during-write to the same register returns the old value.
- Write takes effect at the sampling edge. `led` reflects the new value after that edge.
- Button path latency: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles from a pin change to the BTN_STATE change. The press flag sets on the same edge as the stable change.
- `tick` is registered. It is high in the cycle after the counter reaches PERIOD−1. COUNT and pending update on the same edge that raises `tick`.
- Reset asserted mid-debounce or mid-period discards all progress. No tick is emitted during or after reset until PERIOD is rewritten.

## Test plan
- Reset, bench parameters DEBOUNCE_CYCLES=4, BASE_ADDR=12'hF00:
  - Stimulus: hold CPU_RESETN=0 then release; read offsets 0..5.
  - Required: every read returns 0 with `hit`=1; a read of 12'hEFF returns `hit`=0.
- LED:
  - Stimulus: write 32'hFFFF_A5A5 to 12'hF02.
  - Required: `led`=16'hA5A5 after the edge; read of 12'hF02 returns 32'h0000_A5A5.
- Debounce:
  - Stimulus: 3-cycle high glitch on `btn_raw[1]`.
  - Required: BTN_STATE stays 0 and BTN_PRESS stays 0.
  - Stimulus: hold `btn_raw[1]` high.
  - Required: BTN_STATE=4'b0010 exactly 6 cycles after the pin rises; BTN_PRESS=4'b0010.
  - Stimulus: write 4'b0010 to 12'hF01.
  - Required: BTN_PRESS reads 0.
- Timer:
  - Stimulus: write PERIOD=5.
  - Required: `tick` pulses every 5 cycles; after 3 ticks TICK_COUNT=3 and STATUS=1.
  - Stimulus: write STATUS=1.
  - Required: STATUS reads 0.
- Collisions:
  - W1C of STATUS on the tick edge leaves STATUS=1.
  - Press-set coinciding with W1C of that bit leaves the flag at 1.
  - A TICK_COUNT write on the tick edge gives COUNT=0.
- Reset mid-operation:
  - Stimulus: assert CPU_RESETN with PERIOD=5 and a button debounce half complete.
  - Required: immediately `led`=0, `tick`=0, PERIOD=0; no `tick` appears within 20 cycles after release.
